// File: rtl/per_timer_mc.sv
// Multi-channel memory-mapped timer: per-channel COUNT/COMPARE with overflow flag and level IRQ.
// Optional per-channel 16-bit prescaler is built only when PER_TIMER_MC_PRESCALER_EN is defined.
module per_timer_mc #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CNT_W  = 32
) (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic [15:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    input  logic [1:0]  size_i,
    input  logic        rd_i,
    input  logic        wr_i,
    output logic        irq_o
);

    localparam int unsigned DW    = 32;
    localparam int unsigned PW    = 16;
    localparam int unsigned CH_AW = 4;
    localparam logic [15:0] IRQ_STATUS_ADDR = 16'h0100;

    logic [NUM_CH-1:0] ch_sel;
    logic [NUM_CH-1:0] ovf_vec;
    logic [NUM_CH-1:0] irq_en_vec;
    logic [DW-1:0]     ch_rd [NUM_CH];
    logic [DW-1:0]     rd_val;
    logic              ch_space;
    logic [1:0]        reg_off;
    logic              unused_bits;

    assign ch_space    = (addr_i[15:8] == 8'h00) && (addr_i[1:0] == 2'b00);
    assign reg_off     = addr_i[3:2];
    assign unused_bits = ^{size_i, wdata_i};

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic             en_q;
        logic             ovf_q;
        logic             oneshot_q;
        logic             irq_en_q;
        logic [CNT_W-1:0] count_q;
        logic [CNT_W-1:0] compare_q;
        logic             tick;
        logic             match;
        logic             wr_csr;
        logic             wr_cnt;
        logic             wr_cmp;
        logic [DW-1:0]    rd_c;

        assign ch_sel[i] = ch_space && (addr_i[7:4] == CH_AW'(i));
        assign wr_csr    = wr_i && ch_sel[i] && (reg_off == 2'd0);
        assign wr_cnt    = wr_i && ch_sel[i] && (reg_off == 2'd1);
        assign wr_cmp    = wr_i && ch_sel[i] && (reg_off == 2'd2);

`ifdef PER_TIMER_MC_PRESCALER_EN
        logic [PW-1:0] presc_q;
        logic [PW-1:0] pcnt_q;
        logic          wr_pre;

        assign wr_pre = wr_i && ch_sel[i] && (reg_off == 2'd3);
        assign tick   = en_q && (pcnt_q == presc_q);

        // Prescale counter parks at 0 while the channel is disabled.
        always_ff @(posedge clk_i or negedge reset_n_i) begin
            if (!reset_n_i) begin
                presc_q <= '0;
                pcnt_q  <= '0;
            end else begin
                if (wr_pre) presc_q <= wdata_i[PW-1:0];
                if (!en_q || tick) pcnt_q <= '0;
                else               pcnt_q <= pcnt_q + PW'(1);
            end
        end
`else
        assign tick = en_q;
`endif

        assign match = tick && (count_q == compare_q);

        // Overflow set by a match beats a simultaneous software clear.
        always_ff @(posedge clk_i or negedge reset_n_i) begin
            if (!reset_n_i) begin
                en_q      <= 1'b0;
                ovf_q     <= 1'b0;
                oneshot_q <= 1'b0;
                irq_en_q  <= 1'b0;
                count_q   <= '0;
                compare_q <= '0;
            end else begin
                if (wr_csr && wdata_i[0])                             en_q <= 1'b1;
                else if ((wr_csr && wdata_i[1]) || (match && oneshot_q)) en_q <= 1'b0;

                if (match)                      ovf_q <= 1'b1;
                else if (wr_csr && wdata_i[2])  ovf_q <= 1'b0;

                if (wr_csr) begin
                    oneshot_q <= wdata_i[3];
                    irq_en_q  <= wdata_i[4];
                end

                if (wr_cnt)     count_q <= wdata_i[CNT_W-1:0];
                else if (match) count_q <= '0;
                else if (tick)  count_q <= count_q + CNT_W'(1);

                if (wr_cmp) compare_q <= wdata_i[CNT_W-1:0];
            end
        end

        always_comb begin
            rd_c = '0;
            case (reg_off)
                2'd0: rd_c = DW'({irq_en_q, oneshot_q, ovf_q, !en_q, en_q});
                2'd1: rd_c = DW'(count_q);
                2'd2: rd_c = DW'(compare_q);
                2'd3: begin
`ifdef PER_TIMER_MC_PRESCALER_EN
                    rd_c = DW'(presc_q);
`else
                    rd_c = '0;
`endif
                end
            endcase
        end

        assign ch_rd[i]      = rd_c;
        assign ovf_vec[i]    = ovf_q;
        assign irq_en_vec[i] = irq_en_q;
    end

    always_comb begin
        rd_val = '0;
        if (addr_i == IRQ_STATUS_ADDR) begin
            rd_val = DW'(ovf_vec);
        end else begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (ch_sel[i]) rd_val = ch_rd[i];
            end
        end
    end

    // Read data holds between reads; IRQ is a registered OR of enabled overflows.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rdata_o <= '0;
            irq_o   <= 1'b0;
        end else begin
            irq_o <= |(ovf_vec & irq_en_vec);
            if (rd_i) rdata_o <= rd_val;
        end
    end

endmodule

// File: tb/tb_per_timer_mc.sv
// Directed self-checking bench for per_timer_mc: default instance plus an 8-bit, 2-channel instance.
module tb_per_timer_mc;

`ifdef PER_TIMER_MC_PRESCALER_EN
    localparam bit PRE = 1'b1;
`else
    localparam bit PRE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        rd;
    logic        wr_a;
    logic        wr_b;
    logic [31:0] rdata_a;
    logic [31:0] rdata_b;
    logic        irq_a;
    logic        irq_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    per_timer_mc #(.NUM_CH(4), .CNT_W(32)) u_dut_a (
        .clk_i(clk), .reset_n_i(reset_n), .addr_i(addr), .wdata_i(wdata),
        .rdata_o(rdata_a), .size_i(size), .rd_i(rd), .wr_i(wr_a), .irq_o(irq_a)
    );

    per_timer_mc #(.NUM_CH(2), .CNT_W(8)) u_dut_b (
        .clk_i(clk), .reset_n_i(reset_n), .addr_i(addr), .wdata_i(wdata),
        .rdata_o(rdata_b), .size_i(size), .rd_i(rd), .wr_i(wr_b), .irq_o(irq_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // All bus tasks are entered on a falling edge; the access lands on the next rising edge.
    task automatic bus_wr(input bit b, input logic [15:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        if (b) wr_b = 1'b1;
        else   wr_a = 1'b1;
        @(negedge clk);
        wr_a = 1'b0;
        wr_b = 1'b0;
    endtask

    task automatic bus_rd(input bit b, input logic [15:0] a, output logic [31:0] d);
        addr = a;
        rd   = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        d  = b ? rdata_b : rdata_a;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        logic [31:0] v;
        int p;
        int n;

        reset_n = 1'b0;
        addr = '0; wdata = '0; size = 2'b01; rd = 1'b0; wr_a = 1'b0; wr_b = 1'b0;
        idle(2);
        check("rst_rdata_a", rdata_a, 32'h0);
        check("rst_irq_a", 32'(irq_a), 32'h0);
        check("rst_rdata_b", rdata_b, 32'h0);
        reset_n = 1'b1;
        idle(2);

        // Channel 0 free-running period of COMPARE+1
        bus_wr(0, 16'h0008, 32'd5);
        bus_wr(0, 16'h000C, 32'd0);
        bus_wr(0, 16'h0000, 32'h01);
        for (int k = 0; k <= 6; k++) begin
            bus_rd(0, 16'h0004, v);
            check($sformatf("c0_cnt_e%0d", k), v, (k == 6) ? 32'd0 : 32'(k));
        end
        bus_rd(0, 16'h0100, v);
        check("c0_irq_status", v, 32'h1);
        for (int k = 8; k <= 12; k++) begin
            bus_rd(0, 16'h0004, v);
            check($sformatf("c0_cnt_e%0d", k), v, (k == 12) ? 32'd0 : 32'(k - 6));
        end
        bus_rd(0, 16'h0004, v);
        check("c0_cnt_e13", v, 32'd1);
        bus_rd(0, 16'h00F0, v);
        check("unmapped_0f0", v, 32'h0);
        bus_rd(0, 16'h0004, v);
        check("c0_cnt_e15", v, 32'd3);
        bus_rd(0, 16'h0200, v);
        check("unmapped_200", v, 32'h0);
        bus_rd(0, 16'h0004, v);
        check("c0_cnt_e17", v, 32'd5);
        idle(2);
        check("rdata_hold", rdata_a, 32'd5);
        bus_wr(0, 16'h0000, 32'h06);
        bus_rd(0, 16'h0100, v);
        check("c0_ovf_cleared", v, 32'h0);

        // Channel 1 one-shot with IRQ
        p = PRE ? 4 : 1;
        n = 3 * p;
        bus_wr(0, 16'h0018, 32'd2);
        bus_wr(0, 16'h001C, 32'd3);
        bus_wr(0, 16'h0010, 32'h19);
        for (int k = 0; k <= n; k++) begin
            bus_rd(0, 16'h0014, v);
            check($sformatf("c1_cnt_e%0d", k), v, (k == n) ? 32'd0 : 32'(k / p));
            check($sformatf("c1_irq_e%0d", k + 1), 32'(irq_a), (k == n) ? 32'd1 : 32'd0);
        end
        bus_rd(0, 16'h0010, v);
        check("c1_csr_done", v, 32'h1E);
        idle(5);
        bus_rd(0, 16'h0014, v);
        check("c1_cnt_stays", v, 32'd0);
        bus_wr(0, 16'h0010, 32'h04);
        check("c1_irq_lag", 32'(irq_a), 32'd1);
        idle(1);
        check("c1_irq_drop", 32'(irq_a), 32'd0);

        // Channel 2 clear colliding with a match keeps the overflow
        bus_wr(0, 16'h0028, 32'd3);
        bus_wr(0, 16'h0020, 32'h11);
        idle(7);
        bus_wr(0, 16'h0020, 32'h14);
        bus_rd(0, 16'h0020, v);
        check("c2_csr_collide", v, 32'h15);
        bus_rd(0, 16'h0024, v);
        check("c2_cnt_after", v, 32'd1);
        check("c2_irq_high", 32'(irq_a), 32'd1);
        bus_wr(0, 16'h0020, 32'h14);
        check("c2_irq_lag", 32'(irq_a), 32'd1);
        idle(1);
        check("c2_irq_drop", 32'(irq_a), 32'd0);
        bus_wr(0, 16'h0020, 32'h06);
        idle(2);

        // 8-bit instance: COMPARE below COUNT wraps without overflow
        bus_wr(1, 16'h0004, 32'hABCD_0010);
        bus_wr(1, 16'h0008, 32'h1234_5605);
        bus_wr(1, 16'h0000, 32'h01);
        idle(239);
        bus_rd(1, 16'h0004, v);
        check("b_cnt_ff", v, 32'h0000_00FF);
        bus_rd(1, 16'h0004, v);
        check("b_cnt_wrap", v, 32'h0);
        bus_rd(1, 16'h0100, v);
        check("b_no_ovf_wrap", v, 32'h0);
        idle(3);
        bus_rd(1, 16'h0100, v);
        check("b_no_ovf_pre", v, 32'h0);
        bus_rd(1, 16'h0004, v);
        check("b_cnt_match", v, 32'h0);
        bus_rd(1, 16'h0100, v);
        check("b_ovf_set", v, 32'h1);
        check("b_irq_off", 32'(irq_b), 32'd0);
        bus_rd(1, 16'h0008, v);
        check("b_cmp_trunc", v, 32'h05);
        bus_wr(1, 16'h0024, 32'h55);
        bus_rd(1, 16'h0024, v);
        check("b_ch2_absent", v, 32'h0);

        // Channel 3 prescale access, then reset mid-count
        bus_wr(0, 16'h003C, 32'd7);
        bus_rd(0, 16'h003C, v);
        check("c3_presc_rd", v, PRE ? 32'd7 : 32'd0);
        bus_wr(0, 16'h0038, 32'h0000_FFFF);
        bus_wr(0, 16'h0000, 32'h11);
        bus_wr(0, 16'h0030, 32'h01);
        p = PRE ? 8 : 1;
        for (int k = 0; k <= 3; k++) begin
            bus_rd(0, 16'h0034, v);
            check($sformatf("c3_cnt_e%0d", k), v, 32'(k / p));
        end
        idle(4);
        check("c0_irq_pre_rst", 32'(irq_a), 32'd1);
        bus_rd(0, 16'h0034, v);
        check("c3_cnt_e8", v, PRE ? 32'd1 : 32'd8);
        reset_n = 1'b0;
        #1;
        check("mid_rst_rdata", rdata_a, 32'h0);
        check("mid_rst_irq", 32'(irq_a), 32'd0);
        idle(1);
        reset_n = 1'b1;
        idle(3);
        bus_rd(0, 16'h0034, v);
        check("c3_cnt_post_rst", v, 32'h0);
        bus_rd(0, 16'h0030, v);
        check("c3_csr_post_rst", v, 32'h2);
        bus_rd(0, 16'h0038, v);
        check("c3_cmp_post_rst", v, 32'h0);
        bus_rd(0, 16'h003C, v);
        check("c3_presc_post_rst", v, 32'h0);
        idle(5);
        bus_rd(0, 16'h0034, v);
        check("c3_cnt_static", v, 32'h0);
        bus_rd(0, 16'h0100, v);
        check("irq_status_post_rst", v, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/per_timer_mc.md
PER_TIMER_MC -- requirements
Module: per_timer_mc

Interface
REQ-001 Clocking SHALL be: one clock; reset is asynchronous and active-low.
REQ-002 Parameter NUM_CH, default 4, number of timer channels, legal 1..8.
REQ-003 Parameter CNT_W, default 32, counter/compare width, legal 8..32.
REQ-004 clk_i  input  1  system clock; all state on rising edge.
REQ-005 reset_n_i  input  1  asynchronous active-low reset.
REQ-006 addr_i  input  16  byte address of register access.
REQ-007 wdata_i  input  32  write data.
REQ-008 rdata_o  output  32  registered read data.
REQ-009 size_i  input  2  access size; ignored, all accesses treated as 32-bit.
REQ-010 rd_i  input  1  read strobe, single cycle.
REQ-011 wr_i  input  1  write strobe, single cycle.
REQ-012 irq_o  output  1  registered interrupt, level, active-high.

Function
REQ-013 Channel n registers SHALL be at n*0x10: CSR +0x0, COUNT +0x4, COMPARE +0x8, PRESCALE +0xC; global IRQ_STATUS SHALL be at 0x100 (read-only, bit n = channel n overflow).
REQ-014 CSR write SHALL act as: bit0=1 sets enable; else bit1=1 clears enable; bit2=1 clears overflow; bits3 (ONESHOT) and 4 (IRQ_EN) loaded directly.
REQ-015 CSR read SHALL return bit0 enable, bit1 !enable, bit2 overflow, bit3 ONESHOT, bit4 IRQ_EN, bits31:5 zero.
REQ-016 Per-channel 16-bit prescale counter SHALL count while enabled and produce tick when equal to PRESCALE[15:0], then return to 0; disabled channel holds prescale counter at 0.
REQ-017 Match SHALL be enable && tick && COUNT==COMPARE; on match COUNT goes to 0 and overflow sets the next edge.
REQ-018 On match with ONESHOT=1, enable SHALL clear on the same edge; COUNT ends at 0.
REQ-019 COUNT priority SHALL be: COUNT write > match > increment on tick > hold.
REQ-020 Overflow priority SHALL be: match set wins over simultaneous write-1-to-clear (event never lost).
REQ-021 COUNT/COMPARE writes SHALL truncate to CNT_W bits; reads zero-extend.
REQ-022 If COMPARE is below COUNT, COUNT SHALL run to 2^CNT_W-1, wrap to 0 without setting overflow, then match normally.
REQ-023 rdata_o SHALL update one cycle after rd_i with addressed value and hold otherwise; unmapped or channel>=NUM_CH addresses read 0, writes ignored.
REQ-024 irq_o SHALL be registered OR over channels of (overflow && IRQ_EN), asserting one cycle after overflow sets and deasserting one cycle after clear.
REQ-025 Channels SHALL be fully independent; a write touches only the addressed register.

Reset
REQ-026 reset_n_i low SHALL immediately clear enable, overflow, ONESHOT, IRQ_EN, COUNT, COMPARE, PRESCALE, prescale counters, rdata_o (0) and irq_o (0), regardless of in-flight activity.
REQ-027 After reset release, no channel SHALL count until software sets enable.

Configuration
REQ-028 Macro PER_TIMER_MC_PRESCALER_EN defined: PRESCALE registers and prescale counters SHALL exist per REQ-016.
REQ-029 Macro PER_TIMER_MC_PRESCALER_EN undefined: no prescale logic; tick SHALL be constant 1; PRESCALE reads 0, writes ignored.

Verification
REQ-030 Ch0 COMPARE=5, PRESCALE=0, CSR=0x01 -> overflow set 6 cycles after enable, COUNT back to 0, repeats every 6 cycles.
REQ-031 Ch1 COMPARE=2, PRESCALE=3, CSR=0x19 (enable, ONESHOT, IRQ_EN) -> COUNT steps every 4 cycles, overflow and irq_o high after 12 cycles, enable reads 0, COUNT stays 0.
REQ-032 Ch2 overflow pending, CSR write 0x04 on same edge as new match -> overflow remains 1; later 0x04 write alone -> overflow 0, irq_o drops one cycle later.
REQ-033 CNT_W=8, COUNT=0x10, COMPARE=0x05, enable -> COUNT wraps 0xFF->0x00 without overflow, overflow at next COUNT==0x05.
REQ-034 Ch3 running, reset_n_i pulsed low mid-count -> all reads 0, irq_o 0 immediately; COUNT static after release.
REQ-035 Read 0x0F0 and 0x200 -> rdata_o 0; without PER_TIMER_MC_PRESCALER_EN write PRESCALE=7 -> reads 0, COUNT increments every cycle.
